// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_decoder_if
//  Description : Bundles the scanned display lines that seg7_scan_decoder
//                samples and the decoded readout it returns.
//                master : drives sample_en / seg_in / an_in, reads results
//                slave  : the decoder itself
//  Ports       : sample_en  - capture strobe
//                seg_in     - segment levels, bit0=a .. bit6=g
//                an_in      - one-hot digit select
//                bcd_out    - committed codes, digit i at [4i+3:4i]
//                valid_out  - a frame has committed since reset
//                frame_done - one-cycle pulse per completed frame
//                err        - last completed frame held an illegal pattern
//                err_digit  - lowest illegal digit index of that frame
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_decoder_if #(
    parameter int NDIG = 4
);
    logic                  sample_en;
    logic [6:0]            seg_in;
    logic [NDIG-1:0]       an_in;
    logic [4*NDIG-1:0]     bcd_out;
    logic                  valid_out;
    logic                  frame_done;
    logic                  err;
    logic [2:0]            err_digit;

    modport master (
        output sample_en, seg_in, an_in,
        input  bcd_out, valid_out, frame_done, err, err_digit
    );

    modport slave (
        input  sample_en, seg_in, an_in,
        output bcd_out, valid_out, frame_done, err, err_digit
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_decoder
//  Description : Loopback checker for a multiplexed 7-segment display.
//                Decodes each accepted (one-hot) scan sample back to a BCD
//                code, assembles one code per digit into a frame, and
//                commits the frame to bcd_out only after STABLE_FRAMES
//                consecutive identical legal frames.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous reset, active-high
//                bus  - seg7_scan_decoder_if.slave (scan inputs, readout)
//  Parameters  : NDIG          - scanned digits, 1..8
//                STABLE_FRAMES - identical legal frames before commit, 1..15
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
    parameter int NDIG          = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    seg7_scan_decoder_if.slave     bus
);

    localparam logic [3:0]          c_stable  = 4'(STABLE_FRAMES);
    localparam logic [NDIG-1:0]     c_all     = {NDIG{1'b1}};
    localparam logic [4*NDIG-1:0]   c_blank   = {NDIG{4'hF}};
    localparam logic [3:0]          c_illegal = 4'hE;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_EVAL    = 1'b1
    } state_t;

    state_t                 r_state;
    logic [NDIG-1:0]        r_seen;
    logic [4*NDIG-1:0]      r_buf;
    logic [4*NDIG-1:0]      r_cand;
    logic [4*NDIG-1:0]      r_prev;
    logic [3:0]             r_count;
    logic [4*NDIG-1:0]      r_bcd;
    logic                   r_valid;
    logic                   r_err;
    logic [2:0]             r_err_digit;

    logic                   w_accept;
    logic [3:0]             w_code;
    logic [NDIG-1:0]        w_seen_next;
    logic                   w_complete;
    logic [4*NDIG-1:0]      w_buf_next;
    logic [NDIG-1:0]        w_illegal;
    logic [2:0]             w_err_digit;
    logic [3:0]             w_count_next;

    // Inverse of the display's BCD-to-segment encoder; anything else is E.
    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        logic [3:0] code;
        case (s)
            7'h3F:   code = 4'h0;
            7'h06:   code = 4'h1;
            7'h5B:   code = 4'h2;
            7'h4F:   code = 4'h3;
            7'h66:   code = 4'h4;
            7'h6D:   code = 4'h5;
            7'h7D:   code = 4'h6;
            7'h07:   code = 4'h7;
            7'h7F:   code = 4'h8;
            7'h6F:   code = 4'h9;
            7'h00:   code = 4'hF;
            default: code = c_illegal;
        endcase
        return code;
    endfunction

    // Only a single active anode identifies a digit unambiguously.
    assign w_accept    = bus.sample_en && ($countones(bus.an_in) == 1);
    assign w_code      = seg_decode(bus.seg_in);
    assign w_seen_next = r_seen | bus.an_in;
    assign w_complete  = w_accept && (w_seen_next == c_all);

    // Buffer with the current sample merged in, so the completing sample
    // lands in the candidate on the same edge it is captured.
    always_comb begin
        w_buf_next = r_buf;
        for (int i = 0; i < NDIG; i++) begin
            if (w_accept && bus.an_in[i]) begin
                w_buf_next[4*i +: 4] = w_code;
            end
        end
    end

    // Scan downward so the lowest illegal index is the one that sticks.
    always_comb begin
        w_illegal   = '0;
        w_err_digit = 3'd0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            w_illegal[i] = (r_cand[4*i +: 4] == c_illegal);
            if (w_illegal[i]) begin
                w_err_digit = 3'(i);
            end
        end
    end

    // Match count saturates at STABLE_FRAMES so a steady display keeps
    // re-committing the same value without further counting.
    always_comb begin
        w_count_next = 4'd1;
        if (|w_illegal) begin
            w_count_next = 4'd0;
        end else if (r_cand == r_prev) begin
            w_count_next = (r_count >= c_stable) ? c_stable : r_count + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_COLLECT;
            r_seen      <= '0;
            r_buf       <= c_blank;
            r_cand      <= c_blank;
            r_prev      <= c_blank;
            r_count     <= 4'd0;
            r_bcd       <= c_blank;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_err_digit <= 3'd0;
        end else begin
            // Collection runs in both states so EVAL overlaps the next frame.
            if (w_accept) begin
                r_buf <= w_buf_next;
                r_seen <= w_complete ? '0 : w_seen_next;
            end
            if (w_complete) begin
                r_cand <= w_buf_next;
            end

            case (r_state)
                ST_COLLECT: begin
                    if (w_complete) begin
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    r_err       <= |w_illegal;
                    r_err_digit <= w_err_digit;
                    r_count     <= w_count_next;
                    r_prev      <= r_cand;
                    if (!(|w_illegal) && (w_count_next == c_stable)) begin
                        r_bcd   <= r_cand;
                        r_valid <= 1'b1;
                    end
                    // A single-digit display can complete again right here.
                    r_state <= w_complete ? ST_EVAL : ST_COLLECT;
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    assign bus.bcd_out    = r_bcd;
    assign bus.valid_out  = r_valid;
    assign bus.frame_done = (r_state == ST_EVAL);
    assign bus.err        = r_err;
    assign bus.err_digit  = r_err_digit;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_decoder
//  Description : Directed self-checking bench for seg7_scan_decoder
//                (NDIG=4, STABLE_FRAMES=2). Inputs change on the falling
//                edge; outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int NDIG          = 4;
    localparam int STABLE_FRAMES = 2;

    // Segment patterns for digits 0..9 and blank
    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F,
                           S4 = 7'h66, S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07,
                           S8 = 7'h7F, S9 = 7'h6F, SB = 7'h00;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seg7_scan_decoder_if #(.NDIG(NDIG)) bus ();

    seg7_scan_decoder #(
        .NDIG          (NDIG),
        .STABLE_FRAMES (STABLE_FRAMES)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One accepted-or-rejected sample, presented for one clock.
    task automatic drive(input logic [3:0] an, input logic [6:0] seg);
        @(negedge clk);
        bus.sample_en = 1'b1;
        bus.an_in     = an;
        bus.seg_in    = seg;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sample_en = 1'b0;
        bus.an_in     = '0;
        bus.seg_in    = '0;
    endtask

    // Plain scan order 0,1,2,3.
    task automatic frame(input logic [6:0] s3, input logic [6:0] s2,
                         input logic [6:0] s1, input logic [6:0] s0);
        drive(4'b0001, s0);
        drive(4'b0010, s1);
        drive(4'b0100, s2);
        drive(4'b1000, s3);
    endtask

    // Call right after the completing sample was driven: checks the EVAL
    // pulse, then the registered results one cycle later.
    task automatic post_frame(input string tag, input logic [15:0] bcd,
                              input logic vld, input logic e,
                              input logic [2:0] ed);
        idle();
        check({tag, ".fdone"}, 32'(bus.frame_done), 32'd1);
        idle();
        check({tag, ".fdone_off"}, 32'(bus.frame_done), 32'd0);
        check({tag, ".bcd"},   32'(bus.bcd_out),   32'(bcd));
        check({tag, ".valid"}, 32'(bus.valid_out), 32'(vld));
        check({tag, ".err"},   32'(bus.err),       32'(e));
        check({tag, ".errd"},  32'(bus.err_digit), 32'(ed));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.sample_en = 1'b0;
        bus.an_in     = '0;
        bus.seg_in    = '0;

        // ---- reset values
        @(negedge clk);
        @(negedge clk);
        check("rst.bcd",   32'(bus.bcd_out),    32'hFFFF);
        check("rst.valid", 32'(bus.valid_out),  32'd0);
        check("rst.fdone", 32'(bus.frame_done), 32'd0);
        check("rst.err",   32'(bus.err),        32'd0);
        check("rst.errd",  32'(bus.err_digit),  32'd0);
        rst = 1'b0;

        // ---- reset mid-frame discards the partial frame
        drive(4'b0100, S2);
        drive(4'b1000, S1);
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst2.bcd",   32'(bus.bcd_out),   32'hFFFF);
        check("rst2.valid", 32'(bus.valid_out), 32'd0);
        check("rst2.err",   32'(bus.err),       32'd0);
        drive(4'b0001, S4);
        drive(4'b0010, S3);
        idle();
        check("rst2.nofdone", 32'(bus.frame_done), 32'd0);
        drive(4'b0100, S2);
        drive(4'b1000, S1);
        post_frame("f1_1234", 16'hFFFF, 1'b0, 1'b0, 3'd0);

        // ---- second identical frame commits two cycles after completion
        frame(S1, S2, S3, S4);
        idle();
        check("f2.fdone",      32'(bus.frame_done), 32'd1);
        check("f2.valid_early", 32'(bus.valid_out), 32'd0);
        check("f2.bcd_early",  32'(bus.bcd_out),    32'hFFFF);
        idle();
        check("f2.bcd",   32'(bus.bcd_out),   32'h1234);
        check("f2.valid", 32'(bus.valid_out), 32'd1);

        // ---- changing value: 1235 appears once and never commits
        frame(S1, S2, S3, S4);
        post_frame("f3_1234", 16'h1234, 1'b1, 1'b0, 3'd0);
        frame(S1, S2, S3, S5);
        post_frame("f4_1235", 16'h1234, 1'b1, 1'b0, 3'd0);
        frame(S1, S2, S3, S4);
        post_frame("f5_1234", 16'h1234, 1'b1, 1'b0, 3'd0);
        frame(S1, S2, S3, S4);
        post_frame("f6_1234", 16'h1234, 1'b1, 1'b0, 3'd0);
        frame(S5, S6, S7, S8);
        post_frame("f7_5678", 16'h1234, 1'b1, 1'b0, 3'd0);
        frame(S5, S6, S7, S8);
        post_frame("f8_5678", 16'h5678, 1'b1, 1'b0, 3'd0);

        // ---- illegal patterns
        frame(S5, 7'h01, S7, S8);
        post_frame("ill_d2", 16'h5678, 1'b1, 1'b1, 3'd2);
        frame(7'h7E, S6, 7'h08, S8);
        post_frame("ill_d1d3", 16'h5678, 1'b1, 1'b1, 3'd1);
        frame(S4, S3, S2, S1);
        post_frame("rec1_4321", 16'h5678, 1'b1, 1'b0, 3'd0);
        frame(S4, S3, S2, S1);
        post_frame("rec2_4321", 16'h4321, 1'b1, 1'b0, 3'd0);

        // ---- blanks, scan order 0,3,1,2 with digit1 rewritten (8 then 9)
        for (int k = 0; k < 2; k++) begin
            drive(4'b0001, S8);
            drive(4'b1000, SB);
            drive(4'b0010, S8);
            drive(4'b0010, S9);
            drive(4'b0100, SB);
            if (k == 0) post_frame("blank1", 16'h4321, 1'b1, 1'b0, 3'd0);
            else        post_frame("blank2", 16'hFF98, 1'b1, 1'b0, 3'd0);
        end

        // ---- rejected selects interleaved in a frame
        drive(4'b0001, S7);
        drive(4'b0000, S1);
        drive(4'b0010, S1);
        drive(4'b0101, S0);
        drive(4'b0100, S2);
        idle();
        check("rej.nofdone", 32'(bus.frame_done), 32'd0);
        drive(4'b1000, S3);
        post_frame("rej1_3217", 16'hFF98, 1'b1, 1'b0, 3'd0);
        frame(S3, S2, S1, S7);
        post_frame("rej2_3217", 16'h3217, 1'b1, 1'b0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
